ibex_register_file_remap: RTL and testbench

- Flip-flop register file with a renaming map and a pool of spare physical registers.
- Each write to an architectural register goes to a free physical register and remaps it; the old physical register is retired.
- Retired registers are scrubbed by a background engine, then returned to the free pool. No stale secret stays in a reachable or recently-freed location.
- Drop-in for the core register file: FPGA/Verilator targets, N read ports, 1 write port.

---
 rtl/ibex_register_file_remap.sv | 158 +++++++++++++++
 tb/tb_ibex_register_file_remap.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_remap.sv
// Renaming flip-flop register file: writes land in a fresh physical register and the old one is scrubbed.
// Define REGFILE_SCRUB_RANDOM_EN to scrub with LFSR data instead of WordZeroVal.
module ibex_register_file_remap #(
    parameter bit                    RV32E       = 1'b0,
    parameter int unsigned           DataWidth   = 32,
    parameter int unsigned           NumSpare    = 2,
    parameter int unsigned           NumRead     = 2,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumRead*5-1:0]           raddr_i,
    output logic [NumRead*DataWidth-1:0]   rdata_o,
    input  logic [4:0]                     waddr_a_i,
    input  logic [DataWidth-1:0]           wdata_a_i,
    input  logic                           we_a_i,
    output logic                           scrub_busy_o,
    output logic [3:0]                     free_cnt_o,
    output logic                           err_o
);

    localparam int unsigned NA = RV32E ? 16 : 32;
    localparam int unsigned NP = NA + NumSpare;
    localparam int unsigned PW = $clog2(NP);
    localparam int unsigned AW = RV32E ? 4 : 5;
    localparam int unsigned QW = (NumSpare > 1) ? $clog2(NumSpare) : 1;

    logic [PW-1:0]        map_q [NA];
    logic [DataWidth-1:0] phys_q [1:NP-1];
    logic [PW-1:0]        free_q [NumSpare];
    logic [PW-1:0]        ret_q [NumSpare];
    logic [QW-1:0]        free_head_q, free_tail_q, ret_head_q, ret_tail_q;
    logic [3:0]           free_cnt_q, ret_cnt_q;
    logic                 err_q;

    logic [AW-1:0]        waddr;
    logic                 wr_en, scrub_en, alias_hit, err_set;
    logic [PW-1:0]        alloc_idx, old_idx, scrub_idx;
    logic [DataWidth-1:0] scrub_val;
    logic [AW-1:0]        rd_addr [NumRead];
    logic [PW-1:0]        rd_idx [NumRead];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{waddr_a_i, raddr_i};

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        return (p == QW'(NumSpare - 1)) ? '0 : p + 1'b1;
    endfunction

    // we_a_i is a one-cycle strobe with no back-pressure: a spare is always free.
    assign waddr     = waddr_a_i[AW-1:0];
    assign wr_en     = we_a_i && (waddr != '0);
    assign scrub_en  = (ret_cnt_q != 4'd0);
    assign alloc_idx = free_q[free_head_q];
    assign old_idx   = map_q[waddr];
    assign scrub_idx = ret_q[ret_head_q];

`ifdef REGFILE_SCRUB_RANDOM_EN
    localparam logic [31:0] LfsrPoly = 32'h8020_0003;
    localparam logic [31:0] LfsrSeed = 32'hACE1_2468;
    logic [31:0] lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
        end else if (scrub_en) begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrPoly : 32'h0);
        end
    end

    always_comb begin
        scrub_val = '0;
        for (int b = 0; b < int'(DataWidth); b++) begin
            scrub_val[b] = lfsr_q[b % 32];
        end
    end
`else
    assign scrub_val = WordZeroVal;
`endif

    // Any map entry already pointing at the allocated register means the pools are corrupt.
    always_comb begin
        alias_hit = 1'b0;
        for (int i = 0; i < int'(NA); i++) begin
            if (map_q[i] == alloc_idx) alias_hit = 1'b1;
        end
    end

    assign err_set = (wr_en && (free_cnt_q == 4'd0)) ||
                     (wr_en && alias_hit) ||
                     (scrub_en && !wr_en && (free_cnt_q == 4'(NumSpare))) ||
                     (wr_en && !scrub_en && (ret_cnt_q == 4'(NumSpare)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NA); i++) map_q[i] <= PW'(i);
            for (int i = 0; i < int'(NumSpare); i++) begin
                free_q[i] <= PW'(int'(NA) + i);
                ret_q[i]  <= '0;
            end
            free_head_q <= '0;
            free_tail_q <= '0;
            ret_head_q  <= '0;
            ret_tail_q  <= '0;
            free_cnt_q  <= 4'(NumSpare);
            ret_cnt_q   <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            if (wr_en) begin
                map_q[waddr]        <= alloc_idx;
                free_head_q         <= ptr_inc(free_head_q);
                ret_q[ret_tail_q]   <= old_idx;
                ret_tail_q          <= ptr_inc(ret_tail_q);
            end
            if (scrub_en) begin
                ret_head_q          <= ptr_inc(ret_head_q);
                free_q[free_tail_q] <= scrub_idx;
                free_tail_q         <= ptr_inc(free_tail_q);
            end
            free_cnt_q <= free_cnt_q + {3'd0, scrub_en} - {3'd0, wr_en};
            ret_cnt_q  <= ret_cnt_q + {3'd0, wr_en} - {3'd0, scrub_en};
            if (err_set) err_q <= 1'b1;
        end
    end

    // Allocated and scrubbed registers are never the same index in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < int'(NP); i++) phys_q[i] <= WordZeroVal;
        end else begin
            for (int i = 1; i < int'(NP); i++) begin
                if (wr_en && (alloc_idx == PW'(i))) begin
                    phys_q[i] <= wdata_a_i;
                end else if (scrub_en && (scrub_idx == PW'(i))) begin
                    phys_q[i] <= scrub_val;
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < int'(NumRead); k++) begin
            rd_addr[k] = raddr_i[5*k +: AW];
            rd_idx[k]  = map_q[rd_addr[k]];
            if ((rd_addr[k] == '0) || (rd_idx[k] == '0)) begin
                rdata_o[DataWidth*k +: DataWidth] = WordZeroVal;
            end else begin
                rdata_o[DataWidth*k +: DataWidth] = phys_q[rd_idx[k]];
            end
        end
    end

    assign scrub_busy_o = scrub_en;
    assign free_cnt_o   = free_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ibex_register_file_remap.sv
// Scoreboard bench for ibex_register_file_remap: driver pushes expectations, negedge monitor checks them.
module tb_ibex_register_file_remap;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NS = 2;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NR*5-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [4:0]      waddr;
  logic [DW-1:0]   wdata;
  logic            we;
  logic            busy;
  logic [3:0]      fcnt;
  logic            err;

  always #5 clk = ~clk;

  ibex_register_file_remap #(
    .RV32E(1'b0), .DataWidth(DW), .NumSpare(NS), .NumRead(NR), .WordZeroVal('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .scrub_busy_o(busy), .free_cnt_o(fcnt), .err_o(err)
  );

  logic [DW-1:0] exp_q[$];
  int            kind_q[$];
  int            idx_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] shadow [32];

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic expect_val(input int kind, input int idx, input logic [DW-1:0] val);
    exp_q.push_back(val);
    kind_q.push_back(kind);
    idx_q.push_back(idx);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic expect_status(input int fc, input int bz, input int er);
    expect_val(2, 0, 32'(fc));
    expect_val(3, 0, 32'(bz));
    expect_val(4, 0, 32'(er));
  endtask

  // Monitor: outputs are combinationally stable by the falling edge.
  always @(negedge clk) begin
    logic [DW-1:0] e, act;
    int            k, ix;
    string         nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      ix = idx_q.pop_front();
      case (k)
        0: begin act = rdata[DW-1:0];    nm = "rdata0";   end
        1: begin act = rdata[2*DW-1:DW]; nm = "rdata1";   end
        2: begin act = 32'(fcnt);        nm = "free_cnt"; end
        3: begin act = 32'(busy);        nm = "scrub_busy"; end
        4: begin act = 32'(err);         nm = "err";      end
        5: begin act = 32'(dut.map_q[ix]); nm = "map";    end
        default: begin act = dut.phys_q[ix]; nm = "phys"; end
      endcase
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s[%0d] at %0t: actual=%h expected=%h", nm, ix, $time, act, e);
      end
    end
  end

  initial begin
    logic [DW-1:0] scrub1, scrub2, d;
    int            a, prev;
`ifdef REGFILE_SCRUB_RANDOM_EN
    scrub1 = 32'hACE1_2468;
    scrub2 = lfsr_step(32'hACE1_2468);
`else
    scrub1 = '0;
    scrub2 = '0;
`endif
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset state, then every address reads zero with identity map.
    step();
    expect_status(2, 0, 0);
    step();
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      expect_val(0, 0, '0);
      expect_val(1, 0, '0);
      expect_val(5, i, 32'(i));
      step();
    end
    expect_status(2, 0, 0);

    // Single write to x5, then a second write that recycles the scrubbed register.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; set_reads(5'd5, 5'd0);
    expect_val(0, 0, '0);
    step();
    we = 1'b0;
    expect_val(0, 0, 32'hDEAD_BEEF);
    expect_val(5, 5, 32'd32);
    expect_status(1, 1, 0);
    step();
    expect_val(6, 5, scrub1);
    expect_status(2, 0, 0);
    we = 1'b1; waddr = 5'd5; wdata = 32'h1111_1111;
    step();
    we = 1'b0;
    expect_val(0, 0, 32'h1111_1111);
    expect_val(5, 5, 32'd33);
    expect_status(1, 1, 0);
    step();
    expect_val(6, 32, scrub2);
    expect_val(6, 33, 32'h1111_1111);
    expect_status(2, 0, 0);
    shadow[5] = 32'h1111_1111;

    // Write to x0 is a no-op.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; set_reads(5'd0, 5'd5);
    expect_status(2, 0, 0);
    step();
    we = 1'b0;
    expect_val(0, 0, '0);
    expect_val(1, 0, 32'h1111_1111);
    expect_status(2, 0, 0);
    step();

    // Back-to-back burst: same-cycle reads return the pre-edge value.
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      a = 1 + (i % 31);
      d = (32'(i) * 32'h9E37_79B9) ^ 32'hC0FF_EE00;
      we = 1'b1; waddr = 5'(a); wdata = d;
      set_reads(5'(a), 5'(prev));
      expect_val(0, 0, shadow[a]);
      expect_val(1, 0, shadow[prev]);
      expect_status((i > 0) ? 1 : 2, (i > 0) ? 1 : 0, 0);
      shadow[a] = d;
      prev = a;
      step();
    end
    we = 1'b0;
    expect_status(1, 1, 0);
    step();
    expect_status(2, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      expect_val(0, 0, shadow[i]);
      expect_val(1, 0, shadow[31 - i]);
      step();
    end

    // Write and read x7 on every port in the same cycle.
    we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D; set_reads(5'd7, 5'd7);
    expect_val(0, 0, shadow[7]);
    expect_val(1, 0, shadow[7]);
    step();
    we = 1'b0;
    shadow[7] = 32'hCAFE_F00D;
    expect_val(0, 0, 32'hCAFE_F00D);
    expect_val(1, 0, 32'hCAFE_F00D);
    step();
    step();

    // Reset asserted in the middle of a burst with a scrub pending.
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; waddr = 5'(10 + i); wdata = 32'h5000_0000 + 32'(i);
      if (i > 0) expect_val(3, 0, 32'd1);
      step();
    end
    #1;
    rst_ni = 1'b0; we = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    for (int i = 0; i < 32; i++) begin
      set_reads(5'(i), 5'(31 - i));
      expect_val(0, 0, '0);
      expect_val(1, 0, '0);
      expect_val(5, i, 32'(i));
      if (i == 0) expect_status(2, 0, 0);
      step();
    end
    #2 rst_ni = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'h55AA_55AA; set_reads(5'd3, 5'd12);
    expect_val(1, 0, '0);
    step();
    we = 1'b0;
    expect_val(0, 0, 32'h55AA_55AA);
    expect_val(5, 3, 32'd32);
    step();
    expect_val(6, 3, scrub1);
    expect_status(2, 0, 0);
    step();

    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
